// File: rtl/aes_pkg.sv
// Shared AES decrypt-datapath definitions: state type, FSM encoding for the
// iterative inverse SubBytes unit, and the inverse S-box table.
package aes_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_BYTES = 16;
  localparam int unsigned STATE_W   = BYTE_W * NUM_BYTES;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [BYTE_W-1:0]  byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } inv_sb_state_e;

  // Inverse of the AES S-box, indexed by the substituted byte.
  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/inv_sub_bytes_iter_if.sv
// Handshake bundle for inv_sub_bytes_iter.
//   valid_i/state_i/ready_o : input state handshake (byte i = state_i[i*8+:8])
//   valid_o/state_o/ready_i : output state handshake
// slave  : the substitution unit
// master : the upstream/downstream environment driving it
interface inv_sub_bytes_iter_if;
  import aes_pkg::*;

  logic   valid_i;
  logic   ready_o;
  state_t state_i;
  logic   valid_o;
  logic   ready_i;
  state_t state_o;

  modport slave (
    input  valid_i,
    input  state_i,
    input  ready_i,
    output ready_o,
    output valid_o,
    output state_o
  );

  modport master (
    output valid_i,
    output state_i,
    output ready_i,
    input  ready_o,
    input  valid_o,
    input  state_o
  );

endinterface

// File: rtl/inv_s_box.sv
// Single-byte inverse S-box lookup (combinational).
//   din    : byte to substitute
//   dout_c : InvSbox(din)
module inv_s_box
  import aes_pkg::*;
(
  input  byte_t din,
  output byte_t dout_c
);

  assign dout_c = INV_SBOX[din];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative inverse SubBytes: substitutes LANES bytes of a 128-bit state per
// enabled cycle, NCYC = 16/LANES cycles per state.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : global stall; low freezes all state and blocks handshakes
//   bus        : input (valid_i/ready_o/state_i) and output
//                (valid_o/ready_i/state_o) handshakes
// ready_o is the only combinational output (from en, ready_i and FSM state).
module inv_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  inv_sub_bytes_iter_if.slave  bus
);

  localparam int unsigned NCYC   = NUM_BYTES / LANES;
  localparam int unsigned CNT_W  = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int unsigned LANE_W = LANES * BYTE_W;

  inv_sb_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_t            work_q, work_d;
  logic              valid_q, valid_d;

  logic [LANE_W-1:0] grp_in;
  logic [LANE_W-1:0] grp_out;
  logic              ready_c;
  logic              in_fire;
  logic              out_fire;

  // Group currently addressed by the counter feeds the S-box lanes.
  assign grp_in = work_q[32'(cnt_q) * LANE_W +: LANE_W];

  for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
    inv_s_box u_inv_s_box (
      .din    (grp_in[l*BYTE_W +: BYTE_W]),
      .dout_c (grp_out[l*BYTE_W +: BYTE_W])
    );
  end

  // DONE may accept a new state on the same edge its result is drained.
  assign ready_c  = en && ((state_q == IDLE) || ((state_q == DONE) && bus.ready_i));
  assign in_fire  = bus.valid_i && ready_c;
  assign out_fire = valid_q && bus.ready_i && en;

  // Next-state, counter and work-register update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    valid_d = valid_q;

    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (in_fire) begin
            work_d  = bus.state_i;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end

        BUSY: begin
          work_d[32'(cnt_q) * LANE_W +: LANE_W] = grp_out;
          if (cnt_q == CNT_W'(NCYC - 1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        DONE: begin
          if (out_fire) begin
            if (in_fire) begin
              work_d  = bus.state_i;
              cnt_d   = '0;
              state_d = BUSY;
            end else begin
              state_d = IDLE;
            end
          end
        end

        default: state_d = IDLE;
      endcase

      // valid_o is a registered decode of the next FSM state.
      valid_d = (state_d == DONE);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      valid_q <= valid_d;
    end
  end

  assign bus.ready_o = ready_c;
  assign bus.valid_o = valid_q;
  assign bus.state_o = work_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Self-checking bench for inv_sub_bytes_iter (LANES=4). The reference S-box
// tables are derived from GF(2^8) inversion plus the affine transform, and a
// scoreboard queue is drained by a monitor on output handshakes.
module tb_inv_sub_bytes_iter;
  import aes_pkg::*;

  localparam int unsigned LANES = 4;
  localparam int unsigned NCYC  = 16 / LANES;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;

  inv_sub_bytes_iter_if bus ();

  inv_sub_bytes_iter #(.LANES(LANES)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     checks  = 0;
  int     errors  = 0;
  int     acc_cyc = 0;
  state_t sb_q [$];
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  task automatic build_tables();
    logic [7:0] b;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
        end
      end
      s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
      fwd_tab[x] = s;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic state_t fwd_sub(input state_t s);
    state_t r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = fwd_tab[s[i*8 +: 8]];
    return r;
  endfunction

  // First 'groups' groups substituted, remaining bytes untouched.
  function automatic state_t inv_partial(input state_t s, input int groups);
    state_t r;
    r = s;
    for (int i = 0; i < groups * int'(LANES); i++) r[i*8 +: 8] = inv_tab[s[i*8 +: 8]];
    return r;
  endfunction

  function automatic state_t inv_sub(input state_t s);
    return inv_partial(s, int'(NCYC));
  endfunction

  function automatic state_t rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake pops and compares one expected state.
  initial begin
    state_t exp;
    forever begin
      @(negedge clk);
      if (rst_n && bus.valid_o && bus.ready_i && en) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 128'(bus.valid_o), 128'(0));
        end else begin
          exp = sb_q.pop_front();
          check("data", bus.state_o, exp);
        end
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic accept(input state_t s, input state_t exp);
    int n;
    n = 0;
    bus.valid_i = 1'b1;
    bus.state_i = s;
    @(negedge clk);
    while (!bus.ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready_o) check("accept_timeout", 128'(bus.ready_o), 128'(1));
    else sb_q.push_back(exp);
    @(posedge clk);
    #1;
    acc_cyc     = int'(cyc);
    bus.valid_i = 1'b0;
    bus.state_i = rand_state();
  endtask

  task automatic wait_out(output int lat);
    int n;
    n   = 0;
    lat = -1;
    while (n < 50 && lat < 0) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.valid_o) lat = int'(cyc) - acc_cyc;
      else check("ready_while_busy", 128'(bus.ready_o), 128'(0));
    end
    if (lat < 0) check("output_timeout", 128'(bus.valid_o), 128'(1));
  endtask

  task automatic consume();
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int     lat;
    int     prev_acc;
    int     idx;
    int     guard;
    state_t s;
    state_t a;
    state_t orig;

    build_tables();
    bus.valid_i = 1'b0;
    bus.state_i = '0;
    bus.ready_i = 1'b0;
    en          = 1'b1;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid_o", 128'(bus.valid_o), 128'(0));
    check("reset_state_o", bus.state_o, 128'd0);
    check("reset_ready_o", 128'(bus.ready_o), 128'(1));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All-zero state.
    bus.ready_i = 1'b1;
    accept(128'd0, {16{8'h52}});
    wait_out(lat);
    check("latency_zero", 128'(lat), 128'(NCYC));
    consume();

    // Known bytes with positions preserved.
    accept({4{32'h16ff7c63}}, {4{32'hff7d0100}});
    wait_out(lat);
    check("latency_known", 128'(lat), 128'(NCYC));
    consume();

    // Round trip of the FIPS-197 round-1 start state.
    orig = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
    accept(fwd_sub(orig), orig);
    wait_out(lat);
    consume();

    // Random back-to-back with ready_i high: one state per NCYC+1 cycles.
    prev_acc = 0;
    for (int i = 0; i < 10; i++) begin
      s = rand_state();
      accept(s, inv_sub(s));
      if (i > 0) check("throughput_gap", 128'(acc_cyc - prev_acc), 128'(NCYC + 1));
      prev_acc = acc_cyc;
      wait_out(lat);
      check("latency_b2b", 128'(lat), 128'(NCYC));
    end
    consume();

    // Backpressure in DONE, then drain and accept on the same edge.
    bus.ready_i = 1'b0;
    a = rand_state();
    accept(a, inv_sub(a));
    wait_out(lat);
    check("latency_bp", 128'(lat), 128'(NCYC));
    bus.valid_i = 1'b1;
    bus.state_i = rand_state();
    for (int i = 0; i < 5; i++) begin
      check("bp_state_hold", bus.state_o, inv_sub(a));
      check("bp_valid_hold", 128'(bus.valid_o), 128'(1));
      check("bp_ready_low", 128'(bus.ready_o), 128'(0));
      @(posedge clk);
      #1;
    end
    bus.ready_i = 1'b1;
    s = rand_state();
    accept(s, inv_sub(s));
    check("bp_drained_same_edge", 128'(sb_q.size()), 128'(1));
    wait_out(lat);
    check("latency_after_bp", 128'(lat), 128'(NCYC));
    consume();

    // Stall for 3 cycles after the first group.
    s = rand_state();
    accept(s, inv_sub(s));
    @(posedge clk);
    #1;
    check("stall_pre", bus.state_o, inv_partial(s, 1));
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall_work_frozen", bus.state_o, inv_partial(s, 1));
      check("stall_ready_low", 128'(bus.ready_o), 128'(0));
      check("stall_valid_low", 128'(bus.valid_o), 128'(0));
    end
    en = 1'b1;
    wait_out(lat);
    check("latency_stall", 128'(lat), 128'(NCYC + 3));
    consume();

    // Reset while two groups are done.
    s = rand_state();
    accept(s, inv_sub(s));
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_work", bus.state_o, inv_partial(s, 2));
    rst_n = 1'b0;
    #1;
    check("midreset_valid_o", 128'(bus.valid_o), 128'(0));
    check("midreset_state_o", bus.state_o, 128'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_reset_ready_o", 128'(bus.ready_o), 128'(1));
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("no_stale_output", 128'(bus.valid_o), 128'(0));
    end

    // Random traffic with random stalls and backpressure.
    idx   = 0;
    guard = 0;
    s     = rand_state();
    while (idx < 20 && guard < 3000) begin
      en          = ($urandom_range(0, 3) != 0);
      bus.ready_i = 1'($urandom_range(0, 1));
      bus.valid_i = ($urandom_range(0, 2) != 0);
      bus.state_i = s;
      @(negedge clk);
      if (bus.valid_i && bus.ready_o) begin
        sb_q.push_back(inv_sub(s));
        idx++;
        s = rand_state();
      end
      @(posedge clk);
      #1;
      guard++;
    end
    check("random_all_accepted", 128'(idx), 128'(20));
    bus.valid_i = 1'b0;
    en          = 1'b1;
    bus.ready_i = 1'b1;
    guard       = 0;
    while (sb_q.size() != 0 && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("scoreboard_drained", 128'(sb_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
